xor_descram_rx: RTL and testbench
=================================

Name: xor_descram_rx

Overview:
- Serial receive end for the team's XOR-scrambled link. It is the counterpart of the scrambling transmitter built from 74x86 XOR and 74x74 flip-flop mapped cells.
- Self-synchronising descrambler, polynomial x^7+x^6+1.
- Deserialises LSB-first frames: WIDTH data bits followed by one even-parity bit.
- Checks parity and presents each word through a single-entry valid/ready holding register.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..16).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset.
- S_IN  input  1  scrambled serial bit.
- S_VALID  input  1  S_IN valid this cycle. No backpressure on the serial side.
- S_SOF  input  1  qualified by S_VALID; marks data bit 0 of a frame.
- Y  output  WIDTH  descrambled data word.
- Y_VALID  output  1  holding register full.
- Y_READY  input  1  consumer accepts Y when Y_VALID&&Y_READY.
- PERR  output  1  parity error flag for the word in Y. Valid only with Y_VALID.
- FERR  output  1  one-cycle pulse: frame aborted by a mid-frame S_SOF.
- OVF  output  1  sticky: a completed word was dropped. Cleared only by reset.

Behaviour:
- One clock domain. All state changes at the CLK rising edge; RST_N sampled there.

Reset (RST_N=0 at an edge):
- Outputs: Y=0, Y_VALID=0, PERR=0, FERR=0, OVF=0.
- State: sr=0, state=IDLE, bit count=0.
- A reset mid-frame discards the partial frame and any held word.

Descrambler:
- Applies on every cycle with S_VALID=1, in every state, including IDLE.
- d = S_IN ^ sr[5] ^ sr[6].
- Then sr <= {sr[5:0], S_IN}, so sr[0] is the most recent scrambled bit.
- Cycles with S_VALID=0 change nothing.

Frame FSM (S_VALID=1 cycles only):
- IDLE: S_SOF=1 -> store d as bit 0, cnt=1, go to DATA. Otherwise stay; d is discarded.
- DATA: S_SOF=0 -> store d at bit cnt, cnt++. When cnt reaches WIDTH, go to PARITY.
- DATA: S_SOF=1 -> pulse FERR, discard the partial word, store d as bit 0, cnt=1, stay in DATA.
- PARITY: d is the parity bit. perr = d ^ (XOR-reduce of the data word). Frame completes; go to IDLE.
- PARITY: S_SOF=1 -> pulse FERR, treat this bit as bit 0 of a new frame (DATA, cnt=1). No word completes.
- The parity bit is scrambled like the data bits.

Output holding register:
- Latency: a frame completes on the edge sampling its parity bit. Y, PERR and Y_VALID are updated on that same edge, so Y_VALID=1 from the next cycle.
- Y_VALID=0 at completion: load Y and PERR, set Y_VALID.
- Y_VALID=1 and Y_READY=1 in the completion cycle: load the new word, keep Y_VALID=1. No drop, no OVF.
- Y_VALID=1 and Y_READY=0 in the completion cycle: keep the old word, drop the new one, set OVF.
- No completion and Y_VALID&&Y_READY: clear Y_VALID. Y and PERR hold their last values.
- Y and PERR are stable while Y_VALID=1 and Y_READY=0.
- FERR is high for exactly the cycle after the aborting edge.

Test Plan:
- Zero frame: reset; S_VALID=1; SOF with bit 0; send 8 zero bits then parity 0 -> Y=0x00, PERR=0, Y_VALID=1 one cycle after the parity bit.
- Descrambler taps, WIDTH=8, after reset: scrambled bits 1,0,0,0,0,0,0,0 then parity 1 -> Y=0xC1, PERR=0.
- Parity error: same frame but parity bit 0 -> Y=0xC1, PERR=1.
- Stalls and overflow: S_VALID gaps mid-frame -> same result as the gapless case. Two frames with Y_READY=0 -> Y keeps the first word, OVF=1. Y_READY=1 in the completion cycle of the second frame -> second word loaded, OVF stays 0.
- Abort: S_SOF re-asserted at data bit 4 -> FERR pulses once. The new frame completes normally 9 valid bits later, with no stale bits.
- Reset mid-frame: RST_N=0 at data bit 5 -> all outputs 0, sr=0. A following clean frame decodes as in scenario 2.

Source files
------------

// File: rtl/xor_descram_rx.sv
// rtl/xor_descram_rx.sv - self-synchronising x^7+x^6+1 descrambler and parity-checked frame receiver
module xor_descram_rx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             S_IN,
    input  logic             S_VALID,
    input  logic             S_SOF,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VALID,
    input  logic             Y_READY,
    output logic             PERR,
    output logic             FERR,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic             d;
    logic             done;
    logic             done_perr;
    logic [WIDTH-1:0] d_bit0;

    // Descrambled bit and the word that holds it alone in bit 0 (start of a new frame)
    always_comb begin
        d      = S_IN ^ sr_q[5] ^ sr_q[6];
        d_bit0 = {{(WIDTH-1){1'b0}}, d};
    end

    // Descrambler shift register and frame assembly FSM
    always_comb begin
        sr_d      = sr_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        ferr_d    = 1'b0;
        done      = 1'b0;
        done_perr = 1'b0;
        if (S_VALID) begin
            sr_d = {sr_q[5:0], S_IN};
            case (state_q)
                IDLE: begin
                    if (S_SOF) begin
                        word_d  = d_bit0;
                        cnt_d   = CW'(1);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (S_SOF) begin
                        // Restart: the partial word is thrown away, this bit is bit 0
                        ferr_d = 1'b1;
                        word_d = d_bit0;
                        cnt_d  = CW'(1);
                    end else begin
                        // Bits above cnt are still zero, so OR-ing in place is enough
                        word_d = word_q | (d_bit0 << cnt_q);
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(WIDTH)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (S_SOF) begin
                        ferr_d  = 1'b1;
                        word_d  = d_bit0;
                        cnt_d   = CW'(1);
                        state_d = DATA;
                    end else begin
                        done      = 1'b1;
                        done_perr = d ^ (^word_q);
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Single-entry output holding register with overflow tracking
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        perr_d    = perr_q;
        ovf_d     = ovf_q;
        if (done) begin
            if (!y_valid_q || Y_READY) begin
                y_d       = word_q;
                perr_d    = done_perr;
                y_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (y_valid_q && Y_READY) begin
            y_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Y       = y_q;
    assign Y_VALID = y_valid_q;
    assign PERR    = perr_q;
    assign FERR    = ferr_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_xor_descram_rx.sv
// tb/tb_xor_descram_rx.sv - self-checking bench for xor_descram_rx with a transmitter-side scrambler model
module tb_xor_descram_rx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         S_IN = 1'b0;
    logic         S_VALID = 1'b0;
    logic         S_SOF = 1'b0;
    logic [W-1:0] Y;
    logic         Y_VALID;
    logic         Y_READY = 1'b0;
    logic         PERR;
    logic         FERR;
    logic         OVF;

    int checks = 0;
    int failures = 0;

    bit     tx_hist[$];
    logic   yv_before;

    xor_descram_rx #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .S_IN    (S_IN),
        .S_VALID (S_VALID),
        .S_SOF   (S_SOF),
        .Y       (Y),
        .Y_VALID (Y_VALID),
        .Y_READY (Y_READY),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter line history: seven zeros after reset, newest at the back
    task automatic clear_hist();
        tx_hist.delete();
        for (int i = 0; i < 7; i++) tx_hist.push_back(1'b0);
    endtask

    task automatic push_hist(input bit s);
        tx_hist.push_back(s);
        void'(tx_hist.pop_front());
    endtask

    // Scramble a plain bit: line bit = plain ^ line bit 6 ago ^ line bit 7 ago
    function automatic bit scramble(input bit p);
        return p ^ tx_hist[tx_hist.size()-6] ^ tx_hist[tx_hist.size()-7];
    endfunction

    task automatic drive(input logic v, input logic b, input logic sof);
        @(negedge CLK);
        S_VALID = v;
        S_IN    = b;
        S_SOF   = sof;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        Y_READY = 1'b0;
    endtask

    task automatic send_raw(input bit s, input bit sof);
        push_hist(s);
        drive(1'b1, s, sof);
    endtask

    task automatic send_plain(input bit p, input bit sof, input bit gaps);
        bit s;
        if (gaps && $urandom_range(0, 2) == 0) idle();
        if (gaps && $urandom_range(0, 3) == 0) idle();
        s = scramble(p);
        send_raw(s, sof);
    endtask

    // Full frame; Y_READY is raised only in the parity (completion) cycle when rdy=1
    task automatic send_frame(input logic [W-1:0] data, input bit par, input bit gaps, input bit rdy);
        bit s;
        for (int i = 0; i < W; i++) send_plain(data[i], i == 0, gaps);
        if (gaps && $urandom_range(0, 1) == 0) idle();
        s = scramble(par);
        push_hist(s);
        drive(1'b1, s, 1'b0);
        Y_READY   = rdy;
        yv_before = Y_VALID;
        idle();
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] data, input bit par);
        check({tag, ".yvalid"}, 16'(Y_VALID), 16'd1);
        check({tag, ".y"}, 16'(Y), 16'(data));
        check({tag, ".perr"}, 16'(PERR), 16'(par ^ (^data)));
    endtask

    task automatic consume(input string tag);
        @(negedge CLK);
        S_VALID = 1'b0;
        Y_READY = 1'b1;
        @(negedge CLK);
        Y_READY = 1'b0;
        check({tag, ".drained"}, 16'(Y_VALID), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N   = 1'b0;
        S_VALID = 1'b0;
        S_SOF   = 1'b0;
        Y_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        clear_hist();
    endtask

    task automatic tap_frame(input bit par);
        send_raw(1'b1, 1'b1);
        for (int i = 1; i < W; i++) send_raw(1'b0, 1'b0);
        send_raw(par, 1'b0);
        idle();
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           pa;

        clear_hist();
        do_reset();
        check("rst.y", 16'(Y), 16'h0);
        check("rst.yvalid", 16'(Y_VALID), 16'd0);
        check("rst.perr", 16'(PERR), 16'd0);
        check("rst.ferr", 16'(FERR), 16'd0);
        check("rst.ovf", 16'(OVF), 16'd0);

        // Zero frame: all-zero line bits from a zero history
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("zero.yv_before", 16'(yv_before), 16'd0);
        check_word("zero", 8'h00, 1'b0);
        consume("zero");

        // Tap check straight from reset with fixed line bits
        do_reset();
        tap_frame(1'b1);
        check("tap.yvalid", 16'(Y_VALID), 16'd1);
        check("tap.y", 16'(Y), 16'h00C1);
        check("tap.perr", 16'(PERR), 16'd0);
        consume("tap");

        do_reset();
        tap_frame(1'b0);
        check("perr.y", 16'(Y), 16'h00C1);
        check("perr.perr", 16'(PERR), 16'd1);
        consume("perr");

        // Gaps mid-frame, then overflow with Y_READY held low
        a = 8'($urandom);
        b = 8'($urandom);
        send_frame(a, 1'b1, 1'b1, 1'b0);
        check_word("gap", a, 1'b1);
        send_frame(b, 1'b0, 1'b1, 1'b0);
        check("ovf.y", 16'(Y), 16'(a));
        check("ovf.perr", 16'(PERR), 16'(1'b1 ^ (^a)));
        check("ovf.flag", 16'(OVF), 16'd1);
        consume("ovf");
        send_frame(a, 1'b0, 1'b0, 1'b0);
        check("ovf.sticky", 16'(OVF), 16'd1);
        consume("ovf2");

        // Completion while the consumer accepts: replacement, no drop
        do_reset();
        send_frame(a, 1'b0, 1'b0, 1'b0);
        check_word("rdy1", a, 1'b0);
        send_frame(b, 1'b1, 1'b1, 1'b1);
        check_word("rdy2", b, 1'b1);
        check("rdy.ovf", 16'(OVF), 16'd0);
        consume("rdy");

        // Mid-frame SOF at data bit 4
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 4; i++) send_plain(a[i], i == 0, 1'b0);
        send_plain(b[0], 1'b1, 1'b0);
        idle();
        check("abort.ferr", 16'(FERR), 16'd1);
        idle();
        check("abort.ferr_pulse", 16'(FERR), 16'd0);
        check("abort.nodone", 16'(Y_VALID), 16'd0);
        for (int i = 1; i < W; i++) send_plain(b[i], 1'b0, 1'b1);
        pa = 1'($urandom_range(0, 1));
        push_hist(scramble(pa));
        drive(1'b1, tx_hist[tx_hist.size()-1], 1'b0);
        idle();
        check_word("abort", b, pa);
        consume("abort");

        // Randomized frames with idle junk bits in between
        for (int n = 0; n < 24; n++) begin
            int junk;
            junk = $urandom_range(0, 3);
            for (int j = 0; j < junk; j++) send_plain(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            a  = 8'($urandom);
            pa = 1'($urandom_range(0, 1));
            send_frame(a, pa, 1'b1, 1'b0);
            check_word("rand", a, pa);
            consume("rand");
        end
        check("rand.ovf", 16'(OVF), 16'd0);

        // Reset at data bit 5 with a word still held
        a = 8'($urandom);
        send_frame(a, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_plain(1'($urandom_range(0, 1)), i == 0, 1'b0);
        @(negedge CLK);
        RST_N   = 1'b0;
        S_VALID = 1'b1;
        S_IN    = 1'b1;
        S_SOF   = 1'b0;
        @(negedge CLK);
        S_VALID = 1'b0;
        RST_N   = 1'b1;
        clear_hist();
        check("mrst.y", 16'(Y), 16'h0);
        check("mrst.yvalid", 16'(Y_VALID), 16'd0);
        check("mrst.perr", 16'(PERR), 16'd0);
        check("mrst.ferr", 16'(FERR), 16'd0);
        check("mrst.ovf", 16'(OVF), 16'd0);
        tap_frame(1'b1);
        check("mrst.tap_y", 16'(Y), 16'h00C1);
        check("mrst.tap_perr", 16'(PERR), 16'd0);
        check("mrst.tap_yv", 16'(Y_VALID), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
